gate_truth_checker: RTL and testbench

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

---
 rtl/gate_truth_checker.sv | 126 ++++++++++++
 tb/tb_gate_truth_checker.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives the four {a,b} vectors in Gray order into a gate and checks its y against EXPECT.
// Define GATE_CHECK_STICKY_EN to make fail_vec/err_count accumulate across runs (cleared only by rst).
module gate_truth_checker #(
    parameter int unsigned SETTLE = 1,
    parameter logic [3:0]  EXPECT = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] err_count
);
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d, idx_nx;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d, b_q, b_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       run_fail_q, run_fail_d;
    logic [3:0] fail_vec_q, fail_vec_d;
    logic [2:0] err_q, err_d;
    logic       sample, mism;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        run_fail_d = run_fail_q;
        fail_vec_d = fail_vec_q;
        err_d      = err_q;
        idx_nx     = idx_q + 2'd1;
        sample     = (state_q == DRIVE) && (cnt_q == 4'd0);
        mism       = sample && (y != EXPECT[{a_q, b_q}]);
        case (state_q)
            IDLE: if (start) begin
                state_d    = DRIVE;
                idx_d      = 2'd0;
                cnt_d      = SETTLE_C;
                a_d        = 1'b0;
                b_d        = 1'b0;
                pass_d     = 1'b0;
                run_fail_d = 1'b0;
`ifdef GATE_CHECK_STICKY_EN
                fail_vec_d = fail_vec_q;
                err_d      = err_q;
`else
                fail_vec_d = 4'b0000;
                err_d      = 3'd0;
`endif
            end
            DRIVE: begin
                if (mism) begin
                    fail_vec_d[{a_q, b_q}] = 1'b1;
                    err_d                  = err_q + 3'(err_q != 3'd7);
                    run_fail_d             = 1'b1;
                end
                if (!sample) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (idx_q == 2'd3) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    cnt_d   = 4'd0;
                    pass_d  = !(run_fail_q || mism);
                end else begin
                    // Gray order 00,10,11,01: a = idx[1]^idx[0], b = idx[1]
                    idx_d = idx_nx;
                    a_d   = idx_nx[1] ^ idx_nx[0];
                    b_d   = idx_nx[1];
                    cnt_d = SETTLE_C;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= 4'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            run_fail_q <= 1'b0;
            fail_vec_q <= 4'b0000;
            err_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            run_fail_q <= run_fail_d;
            fail_vec_q <= fail_vec_d;
            err_q      <= err_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == DRIVE);
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_vec  = fail_vec_q;
    assign err_count = err_q;
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: random and directed runs on SETTLE=0 and SETTLE=1 instances against a per-run truth-table model.
module tb_gate_truth_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic [3:0] tt0 = 4'b0111, tt1 = 4'b0111;
    logic y0, y1, a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
    logic [3:0] fv0, fv1;
    logic [2:0] ec0, ec1;
    int n_vec = 0, n_err = 0;
    logic [3:0] m_fail[2];
    logic [2:0] m_err[2];
    logic       m_pass[2];
    logic [1:0] gray_t[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    localparam logic [3:0] EXP = 4'b0111;

    always #5 clk = ~clk;

    // The gate under test is modelled as a truth table indexed by {a,b}.
    assign y0 = tt0[{a0, b0}];
    assign y1 = tt1[{a1, b1}];

    gate_truth_checker #(.SETTLE(0), .EXPECT(EXP)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .y(y0), .a(a0), .b(b0), .busy(busy0),
        .done(done0), .pass(pass0), .fail_vec(fv0), .err_count(ec0));
    gate_truth_checker #(.SETTLE(1), .EXPECT(EXP)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y(y1), .a(a1), .b(b1), .busy(busy1),
        .done(done1), .pass(pass1), .fail_vec(fv1), .err_count(ec1));

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {a,b,busy,done,pass,fail_vec,err_count}
    function automatic logic [11:0] obs(input int sel);
        return sel == 0 ? {a0, b0, busy0, done0, pass0, fv0, ec0}
                        : {a1, b1, busy1, done1, pass1, fv1, ec1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else start1 = v;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            m_fail[i] = 4'b0000;
            m_err[i]  = 3'd0;
            m_pass[i] = 1'b0;
        end
    endtask

    task automatic run(input int sel, input logic [3:0] tt, input int extra, input bit hold);
        int s, n, pc, t;
        logic [3:0] fexp;
        logic [11:0] o;
        s = (sel == 0) ? 0 : 1;
        n = 4 * (s + 1);
        if (sel == 0) tt0 = tt;
        else tt1 = tt;
        chk("idle_hold", obs(sel), {4'b0000, m_pass[sel], m_fail[sel], m_err[sel]});
        set_start(sel, 1'b1);
        step();
        if (!hold) set_start(sel, 1'b0);
        for (int k = 0; k < n; k++) begin
            o = obs(sel);
            chk("drive", o[11:8], {gray_t[k / (s + 1)], 2'b10});
            if (k == extra) set_start(sel, 1'b1);
            else if (!hold) set_start(sel, 1'b0);
            step();
        end
        fexp = tt ^ EXP;
        pc   = $countones(fexp);
`ifdef GATE_CHECK_STICKY_EN
        t = int'(m_err[sel]) + pc;
        m_fail[sel] = m_fail[sel] | fexp;
        m_err[sel]  = (t > 7) ? 3'd7 : 3'(t);
`else
        t = pc;
        m_fail[sel] = fexp;
        m_err[sel]  = 3'(t);
`endif
        m_pass[sel] = (fexp == 4'b0000);
        chk("done", obs(sel), {4'b0001, m_pass[sel], m_fail[sel], m_err[sel]});
        if (extra == n) set_start(sel, 1'b1);
        else if (!hold) set_start(sel, 1'b0);
        step();
        if (!hold) set_start(sel, 1'b0);
        o = obs(sel);
        chk("idle_after", o[11:8], 4'b0000);
        if (hold) begin
            step();
            o = obs(sel);
            chk("restart", o[11:8], 4'b0010);
        end
    endtask

    initial begin
        int sel, n, extra;
        logic [3:0] tt;
        logic any_done;
        clear_model();
        rst = 1'b1;
        step();
        step();
        chk("reset0", obs(0), 12'h000);
        chk("reset1", obs(1), 12'h000);
        rst = 1'b0;
        step();
        run(1, 4'b0111, -1, 1'b0);
        run(1, 4'b1111, -1, 1'b0);
        run(1, 4'b1111, -1, 1'b0);
        run(1, 4'b1000, -1, 1'b0);
        run(0, 4'b0111, -1, 1'b0);
        run(1, 4'b0111, 3, 1'b0);
        run(1, 4'b1111, 8, 1'b0);
        for (int r = 0; r < 24; r++) begin
            sel   = int'($urandom_range(0, 1));
            tt    = 4'($urandom);
            n     = (sel == 0) ? 4 : 8;
            extra = int'($urandom_range(0, n + 3)) - 1;
            if (extra > n) extra = -1;
            repeat ($urandom_range(0, 2)) step();
            run(sel, tt, extra, 1'b0);
        end
        run(1, 4'b1110, -1, 1'b1);
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("abort1", obs(1), 12'h000);
        chk("abort0", obs(0), 12'h000);
        start1 = 1'b0;
        rst = 1'b0;
        clear_model();
        any_done = 1'b0;
        repeat (10) begin
            step();
            any_done = any_done | done0 | done1;
        end
        chk("no_done_after_abort", {11'd0, any_done}, 12'h000);
        run(0, 4'b0111, -1, 1'b0);
        run(1, 4'b0111, -1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
